imm_gen_pipe: RTL

- Pipelined, parametrised successor to the decode-stage immediate extender.
- Accepts instr[31:7] plus a 3-bit immediate-type select over a valid/ready handshake.
- Produces an XLEN-wide sign/zero-extended immediate one cycle later, passes an opaque tag through, and flags and counts illegal selects.
- Sits between the fetch/decode handshake and the execute operand mux. A 2-entry skid keeps full throughput under backpressure.

---
 rtl/imm_gen_pipe_if.sv | 31 +++
 rtl/imm_gen_pipe.sv | 107 ++++++++++
 2 files changed

// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe handshake bundle: upstream instr/select/tag in,
// extended immediate plus illegal flag and error count out.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [24:0]      instr;
  logic [2:0]       imm_src;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  immext;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;
  logic [CNT_W-1:0] err_count;

  modport master (
    output in_valid, instr, imm_src, in_tag, out_ready,
    input  in_ready, out_valid, immext, out_tag,
    input  out_illegal, err_count
  );

  modport slave (
    input  in_valid, instr, imm_src, in_tag, out_ready,
    output in_ready, out_valid, immext, out_tag,
    output out_illegal, err_count
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate extender with 2-entry skid (R + S).
// Define IMM_CSR_EN to decode imm_src=101 as the Zicsr uimm.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  imm_gen_pipe_if.slave   bus
);

  logic [24:0]      w_i;
  logic [31:0]      w_imm32;
  logic [XLEN-1:0]  w_imm;
  logic             w_ill;
  logic             w_acc;
  logic             w_load;

  logic             r_valid;
  logic [XLEN-1:0]  r_imm;
  logic [TAG_W-1:0] r_tag;
  logic             r_ill;
  logic             r_s_valid;
  logic [XLEN-1:0]  r_s_imm;
  logic [TAG_W-1:0] r_s_tag;
  logic             r_s_ill;
  logic [CNT_W-1:0] r_err;

  assign w_i = bus.instr;

  // w_i[k] is instr[k+7]
  always_comb begin
    w_imm32 = '0;
    w_ill   = 1'b0;
    unique case (bus.imm_src)
      3'b000: w_imm32 = {{20{w_i[24]}}, w_i[24:13]};
      3'b001: w_imm32 = {{20{w_i[24]}}, w_i[24:18],
                         w_i[4:0]};
      3'b010: w_imm32 = {{19{w_i[24]}}, w_i[24], w_i[0],
                         w_i[23:18], w_i[4:1], 1'b0};
      3'b011: w_imm32 = {{11{w_i[24]}}, w_i[24], w_i[12:5],
                         w_i[13], w_i[23:14], 1'b0};
      3'b100: w_imm32 = {w_i[24:5], 12'b0};
`ifdef IMM_CSR_EN
      3'b101: w_imm32 = {27'b0, w_i[12:8]};
`endif
      default: w_ill = 1'b1;
    endcase
  end

  assign w_imm  = XLEN'($signed(w_imm32));
  assign w_acc  = bus.in_valid & ~r_s_valid;
  assign w_load = ~r_valid | bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_imm     <= '0;
      r_tag     <= '0;
      r_ill     <= 1'b0;
      r_s_valid <= 1'b0;
      r_s_imm   <= '0;
      r_s_tag   <= '0;
      r_s_ill   <= 1'b0;
      r_err     <= '0;
    end else begin
      if (w_acc && w_ill && r_err != '1)
        r_err <= r_err + 1'b1;
      if (w_load) begin
        if (r_s_valid) begin
          r_valid   <= 1'b1;
          r_imm     <= r_s_imm;
          r_tag     <= r_s_tag;
          r_ill     <= r_s_ill;
          r_s_valid <= w_acc;
          if (w_acc) begin
            r_s_imm <= w_imm;
            r_s_tag <= bus.in_tag;
            r_s_ill <= w_ill;
          end
        end else if (w_acc) begin
          r_valid <= 1'b1;
          r_imm   <= w_imm;
          r_tag   <= bus.in_tag;
          r_ill   <= w_ill;
        end else begin
          r_valid <= 1'b0;
        end
      end else if (w_acc) begin
        // R stalled: park the new item in S
        r_s_valid <= 1'b1;
        r_s_imm   <= w_imm;
        r_s_tag   <= bus.in_tag;
        r_s_ill   <= w_ill;
      end
    end
  end

  assign bus.in_ready    = ~r_s_valid;
  assign bus.out_valid   = r_valid;
  assign bus.immext      = r_imm;
  assign bus.out_tag     = r_tag;
  assign bus.out_illegal = r_ill;
  assign bus.err_count   = r_err;

endmodule
